// File: rtl/wasm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wasm_seq_pkg
// Description : Shared definitions for the WASM execution sequencer: op-class
//               codes, sticky error codes, push-source select encodings and
//               the sequencer state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package wasm_seq_pkg;

    // Decoded op classes
    localparam logic [2:0] c_CLS_ALU   = 3'd0;
    localparam logic [2:0] c_CLS_LOAD  = 3'd1;
    localparam logic [2:0] c_CLS_STORE = 3'd2;
    localparam logic [2:0] c_CLS_CONST = 3'd3;
    localparam logic [2:0] c_CLS_LGET  = 3'd4;
    localparam logic [2:0] c_CLS_LSET  = 3'd5;
    localparam logic [2:0] c_CLS_ILL   = 3'd6;
    localparam logic [2:0] c_CLS_END   = 3'd7;

    // Sticky error codes
    localparam logic [2:0] c_ERR_NONE  = 3'd0;
    localparam logic [2:0] c_ERR_UNDER = 3'd1;
    localparam logic [2:0] c_ERR_OVER  = 3'd2;
    localparam logic [2:0] c_ERR_TMO   = 3'd3;
    localparam logic [2:0] c_ERR_ILL   = 3'd4;

    // Push-source select for the stack write mux
    localparam logic [1:0] c_PSEL_ALU   = 2'b00;
    localparam logic [1:0] c_PSEL_MEM   = 2'b01;
    localparam logic [1:0] c_PSEL_CONST = 2'b10;
    localparam logic [1:0] c_PSEL_LOC   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERR      = 3'd4
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/wasm_depth_chk.sv
`default_nettype none
// ============================================================================
// Module      : wasm_depth_chk
// Description : Combinational operand-stack depth checker. Flags underflow
//               (pop more than held) and overflow (result above ST_DEPTH) and
//               supplies the post-op depth.
// Ports       : i_depth     current occupancy
//               i_pop_num   entries popped
//               i_push_num  entries pushed
//               o_underflow depth < pop
//               o_overflow  depth - pop + push > ST_DEPTH (only if no underflow)
//               o_next      depth - pop + push
// Revision    : 1.0 - initial release
// ============================================================================
module wasm_depth_chk #(
    parameter int ST_DEPTH = 64,
    parameter int POP_MAX  = 3,
    localparam int DW      = $clog2(ST_DEPTH + 1),
    localparam int PW      = $clog2(POP_MAX + 1)
) (
    input  logic [DW-1:0] i_depth,
    input  logic [PW-1:0] i_pop_num,
    input  logic          i_push_num,
    output logic          o_underflow,
    output logic          o_overflow,
    output logic [DW-1:0] o_next
);

    // One extra bit so the overflow compare never wraps.
    localparam int XW = DW + 1;

    logic [XW-1:0] w_depth_x;
    logic [XW-1:0] w_pop_x;
    logic [XW-1:0] w_push_x;
    logic [XW-1:0] w_sum_x;

    assign w_depth_x   = XW'(i_depth);
    assign w_pop_x     = XW'(i_pop_num);
    assign w_push_x    = XW'(i_push_num);
    assign w_sum_x     = w_depth_x - w_pop_x + w_push_x;

    assign o_underflow = (w_depth_x < w_pop_x);
    assign o_overflow  = !o_underflow && (w_sum_x > XW'(ST_DEPTH));
    assign o_next      = w_sum_x[DW-1:0];

endmodule
`default_nettype wire

// File: rtl/wasm_exec_seq.sv
`default_nettype none
// ============================================================================
// Module      : wasm_exec_seq
// Description : Execution sequencer between decoder and datapath. Tracks
//               operand-stack depth, rejects under/overflowing or illegal ops,
//               runs a req/ack handshake with timeout for line-memory loads
//               and reports run/done/error with a sticky error code.
// Ports       : i_clk/i_rst_n clock, async active-low reset
//               i_start, i_clr_err            control pulses
//               i_op_vld/i_op_class/i_pop_num/i_push_num  decoded op
//               o_op_rdy, o_stk_pop, o_stk_push, o_push_sel  issue strobes
//               o_mem_req/i_mem_ack           load handshake
//               o_depth, o_busy, o_done, o_err, o_err_code  status
// Options     : WASM_SEQ_PERF_EN adds o_cyc_cnt (busy cycles) and o_ret_cnt
//               (accepted ops), both saturating and cleared on i_start.
// Revision    : 1.0 - initial release
// ============================================================================
module wasm_exec_seq
    import wasm_seq_pkg::*;
#(
    parameter int ST_WIDTH    = 32,
    parameter int ST_DEPTH    = 64,
    parameter int POP_MAX     = 3,
    parameter int MEM_TIMEOUT = 255,
    localparam int DW         = $clog2(ST_DEPTH + 1),
    localparam int PW         = $clog2(POP_MAX + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_clr_err,
    input  logic          i_op_vld,
    input  logic [2:0]    i_op_class,
    input  logic [PW-1:0] i_pop_num,
    input  logic          i_push_num,
    output logic          o_op_rdy,
    output logic [PW-1:0] o_stk_pop,
    output logic          o_stk_push,
    output logic [1:0]    o_push_sel,
    output logic          o_mem_req,
    input  logic          i_mem_ack,
    output logic [DW-1:0] o_depth,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
`ifdef WASM_SEQ_PERF_EN
    output logic [31:0]   o_cyc_cnt,
    output logic [31:0]   o_ret_cnt,
`endif
    output logic [2:0]    o_err_code
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    if (((ST_DEPTH & (ST_DEPTH - 1)) != 0) || (ST_WIDTH < 1) ||
        (POP_MAX < 1) || (MEM_TIMEOUT < 1)) begin : g_param_chk
        $error("wasm_exec_seq: illegal parameter set");
    end

    seq_state_e    state_q;
    logic [DW-1:0] depth_q;
    logic [2:0]    err_code_q;
    logic [TW-1:0] tmo_q;
    logic          mem_req_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          w_under;
    logic          w_over;
    logic [DW-1:0] w_next_depth;
    logic          w_ill;
    logic          w_is_load;
    logic          w_issue;
    logic          w_ack;
    logic          w_start;

    wasm_depth_chk #(
        .ST_DEPTH (ST_DEPTH),
        .POP_MAX  (POP_MAX)
    ) u_depth_chk (
        .i_depth     (depth_q),
        .i_pop_num   (i_pop_num),
        .i_push_num  (i_push_num),
        .o_underflow (w_under),
        .o_overflow  (w_over),
        .o_next      (w_next_depth)
    );

    assign w_ill     = (i_op_class == c_CLS_ILL);
    assign w_is_load = (i_op_class == c_CLS_LOAD);
    // An op that passes every check; LOAD is issued but not yet retired.
    assign w_issue   = (state_q == ST_RUN) && i_op_vld && !w_ill && !w_under && !w_over;
    assign w_ack     = (state_q == ST_WAIT_MEM) && i_mem_ack;
    assign w_start   = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        o_op_rdy   = (w_issue && !w_is_load) || w_ack;
        o_stk_pop  = w_issue ? i_pop_num : '0;
        o_stk_push = (w_issue && !w_is_load && i_push_num) || w_ack;
        o_push_sel = c_PSEL_ALU;
        if (w_ack) begin
            o_push_sel = c_PSEL_MEM;
        end else if (w_issue) begin
            if (i_op_class == c_CLS_CONST) begin
                o_push_sel = c_PSEL_CONST;
            end else if (i_op_class == c_CLS_LGET) begin
                o_push_sel = c_PSEL_LOC;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            depth_q    <= '0;
            err_code_q <= c_ERR_NONE;
            tmo_q      <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        state_q <= ST_RUN;
                        depth_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_op_vld) begin
                        if (w_ill || w_under || w_over) begin
                            state_q    <= ST_ERR;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= w_ill   ? c_ERR_ILL   :
                                          w_under ? c_ERR_UNDER : c_ERR_OVER;
                        end else if (w_is_load) begin
                            // Pops happen now; the push comes with the ack.
                            state_q   <= ST_WAIT_MEM;
                            depth_q   <= depth_q - DW'(i_pop_num);
                            mem_req_q <= 1'b1;
                            tmo_q     <= '0;
                        end else begin
                            depth_q <= w_next_depth;
                            if (i_op_class == c_CLS_END) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    // Ack is tested first so a same-cycle ack beats the timeout.
                    if (i_mem_ack) begin
                        state_q   <= ST_RUN;
                        depth_q   <= depth_q + DW'(1);
                        mem_req_q <= 1'b0;
                    end else if (tmo_q == TW'(MEM_TIMEOUT - 1)) begin
                        state_q    <= ST_ERR;
                        mem_req_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= c_ERR_TMO;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_ERR: begin
                    if (i_clr_err) begin
                        state_q    <= ST_IDLE;
                        err_q      <= 1'b0;
                        err_code_q <= c_ERR_NONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req  = mem_req_q;
    assign o_depth    = depth_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_err_code = err_code_q;

`ifdef WASM_SEQ_PERF_EN
    logic [31:0] cyc_cnt_q;
    logic [31:0] ret_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else if (w_start) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            if (((state_q == ST_RUN) || (state_q == ST_WAIT_MEM)) && !(&cyc_cnt_q)) begin
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end
            if (o_op_rdy && !(&ret_cnt_q)) begin
                ret_cnt_q <= ret_cnt_q + 32'd1;
            end
        end
    end

    assign o_cyc_cnt = cyc_cnt_q;
    assign o_ret_cnt = ret_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/wasm_exec_seq.md
Name: wasm_exec_seq

Overview:
- Parametrised execution sequencer between the decoder and the datapath (ALU, operand stack, line memory, local memory).
- Adds operand-depth tracking with underflow/overflow checking before issue.
- Adds a request/acknowledge handshake for variable-latency line-memory loads, with a timeout.
- Adds a run/done/error state machine with sticky error codes, replacing the free-running single-cycle issue of the current top.

Parameters:
- ST_WIDTH, 32, operand-stack entry width.
- ST_DEPTH, 64, operand-stack capacity in entries; must be a power of two.
- POP_MAX, 3, maximum pops per op; sets the width of i_pop_num.
- MEM_TIMEOUT, 255, cycles to wait for i_mem_ack before raising the timeout error.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  pulse; IDLE or DONE -> RUN.
- i_clr_err  in  1  pulse; ERR -> IDLE.
- i_op_vld  in  1  decoded op valid.
- i_op_class  in  3  0 ALU, 1 LOAD, 2 STORE, 3 CONST, 4 LGET, 5 LSET, 7 END, 6 illegal.
- i_pop_num  in  $clog2(POP_MAX+1)  entries popped by the op.
- i_push_num  in  1  entries pushed by the op.
- o_op_rdy  out  1  op accepted this cycle.
- o_stk_pop  out  $clog2(POP_MAX+1)  pop strobe count to the stack.
- o_stk_push  out  1  push strobe to the stack.
- o_push_sel  out  2  push source: 00 ALU, 01 load data, 10 constant, 11 local memory.
- o_mem_req  out  1  load request, level.
- i_mem_ack  in  1  load data valid.
- o_depth  out  $clog2(ST_DEPTH+1)  tracked stack occupancy.
- o_busy  out  1  state is RUN or WAIT_MEM.
- o_done  out  1  state is DONE.
- o_err  out  1  state is ERR.
- o_err_code  out  3  1 underflow, 2 overflow, 3 mem timeout, 4 illegal op.

Behaviour:
- Reset: all outputs 0; state IDLE; depth 0; timeout counter 0.
- States: IDLE, RUN, WAIT_MEM, DONE, ERR. All outputs are registered except o_op_rdy, o_stk_pop, o_stk_push and o_push_sel, which are combinational from state and inputs.
- IDLE: i_start -> RUN; depth cleared to 0.
- RUN with i_op_vld high, checks in priority order:
  - illegal class -> ERR, code 4.
  - depth < i_pop_num -> ERR, code 1.
  - depth - i_pop_num + i_push_num > ST_DEPTH -> ERR, code 2.
  - An erroring op is not accepted: o_op_rdy=0 and no strobes.
- RUN, class LOAD, checks passed:
  - o_op_rdy=0, o_stk_pop=i_pop_num that cycle, depth -= pop.
  - Next state WAIT_MEM; o_mem_req=1 from the next cycle.
- RUN, class END: o_op_rdy=1 -> DONE.
- RUN, other classes: single cycle.
  - o_op_rdy=1; strobes driven.
  - push_sel = 10 for CONST, 11 for LGET, 00 otherwise.
  - Depth updated next edge.
- WAIT_MEM:
  - o_mem_req held high; i_op_vld is ignored and the op stays presented.
  - On i_mem_ack: o_stk_push=1, push_sel=01, o_op_rdy=1, depth += 1, req drops next cycle -> RUN.
  - The counter increments each waiting cycle. When it reaches MEM_TIMEOUT without ack -> ERR, code 3.
  - An ack in the same cycle the counter hits MEM_TIMEOUT wins over the timeout.
- DONE: o_done=1; i_start -> RUN with depth cleared.
- ERR: sticky. o_err_code holds its value and all strobes are 0. i_clr_err -> IDLE with code cleared. i_start is ignored.
- Asynchronous reset mid-WAIT_MEM drops o_mem_req immediately; any late ack is ignored in IDLE.
- Depth arithmetic uses $clog2(ST_DEPTH+1)+1 bits internally, so the overflow compare cannot wrap.

Optional Feature:
- Macro WASM_SEQ_PERF_EN.
- When defined: adds o_cyc_cnt (32 bits, counts every cycle in RUN or WAIT_MEM) and o_ret_cnt (32 bits, counts o_op_rdy pulses).
  - Both clear on i_start; both saturate at all-ones.
  - Both hold their value in DONE and ERR.
- When undefined: no such ports and no counter flops.

Decomposition:
- Shared package wasm_seq_pkg holds:
  - the op-class localparams;
  - the err-code localparams;
  - the push_sel encodings, shared with the top-level push mux;
  - the state enum.
- One sub-module, wasm_depth_chk: combinational underflow/overflow check plus the next-depth value, so the stack wrapper can reuse it.

Test Plan:
- Start; CONST, CONST, ALU (pop 2, push 1), END -> depth 1,2,1; o_done=1; 4 o_op_rdy pulses.
- After reset, ALU with pop 2 at depth 0 -> o_err=1, code 1, no strobes; i_clr_err -> IDLE with code 0.
- ST_DEPTH=4: five CONSTs -> fifth rejected, code 2, depth stays 4.
- LOAD (pop 1) at depth 1 with ack after 7 cycles -> o_mem_req high for 7 cycles, push with sel 01, depth 1.
- MEM_TIMEOUT=15 with no ack -> ERR, code 3, exactly 15 cycles after req rises. Ack on cycle 15 -> no error.
- Reset asserted during WAIT_MEM, then a late ack -> all outputs 0; state IDLE; no push.
